// File: rtl/backing_memory.sv
// Main-memory responder: a 2**ADDR_W x DATA_W word store behind a request/response
// handshake with LATENCY cycles of access time. Optional access counters: BACKING_MEMORY_STATS_EN.
module backing_memory #(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 8,
    parameter int LATENCY = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic              RAMWE,
    input  logic [ADDR_W-1:0] AddressToMemory,
    input  logic [DATA_W-1:0] CacheToMemory,
    output logic [DATA_W-1:0] MemoryToCache,
    output logic              RespValid
`ifdef BACKING_MEMORY_STATS_EN
    ,
    output logic [7:0]        ReadCount,
    output logic [7:0]        WriteCount
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt_p0;
    logic              req_we_p0;
    logic [ADDR_W-1:0] req_addr_p0;
    logic [DATA_W-1:0] req_data_p0;
    logic [DATA_W-1:0] store [DEPTH];
    logic              accept;
    logic              access;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign accept = ReqValid && ReqReady;
    assign access = (state == BUSY) && (cnt_p0 == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ReqReady  = 1'b0;
        RespValid = 1'b0;
        case (state)
            IDLE: begin
                ReqReady = 1'b1;
                if (ReqValid) state_nxt = BUSY;
            end
            BUSY: begin
                if (cnt_p0 == '0) state_nxt = DONE;
            end
            DONE: begin
                ReqReady  = 1'b1;
                RespValid = 1'b1;
                state_nxt = ReqValid ? BUSY : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture stage: counter is control, the latched request is plain data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_p0 <= '0;
        end else if (accept) begin
            cnt_p0 <= CNT_W'(LATENCY - 1);
        end else if (state == BUSY && cnt_p0 != '0) begin
            cnt_p0 <= cnt_p0 - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            req_we_p0   <= RAMWE;
            req_addr_p0 <= AddressToMemory;
            req_data_p0 <= CacheToMemory;
        end
    end

    // Access stage: the store and read port are cleared by reset, aborting any pending write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) store[i] <= '0;
            MemoryToCache <= '0;
        end else if (access) begin
            if (req_we_p0) store[req_addr_p0] <= req_data_p0;
            else           MemoryToCache      <= store[req_addr_p0];
        end
    end

`ifdef BACKING_MEMORY_STATS_EN
    // Counted at the edge closing DONE, so a new request accepted there cannot disturb req_we_p0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ReadCount  <= '0;
            WriteCount <= '0;
        end else if (state == DONE) begin
            if (req_we_p0) WriteCount <= sat_inc(WriteCount);
            else           ReadCount  <= sat_inc(ReadCount);
        end
    end
`endif

endmodule

// File: doc/backing_memory.md
Name: backing_memory

Overview:
- Main-memory responder on the memory side of the cache-to-memory interface.
- Serves the cache's write-back traffic (RAMWE, AddressToMemory, CacheToMemory) and its line fills (MemoryToCache).
- Contains a 64x8 word store behind a request/response handshake, with programmable access latency.
- Lets cache benches and top-level integration run against realistic, non-zero-latency memory.

Parameters:
- ADDR_W, 6, address width; store depth is 2**ADDR_W words.
- DATA_W, 8, word width.
- LATENCY, 3, cycles spent in BUSY per access; legal range 1..15.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- ReqValid  in  1  request present this cycle.
- ReqReady  out  1  responder can accept a request this cycle.
- RAMWE  in  1  request type; 1 = write, 0 = read; sampled with ReqValid.
- AddressToMemory  in  ADDR_W  word address; sampled with ReqValid.
- CacheToMemory  in  DATA_W  write data; sampled with ReqValid when RAMWE=1.
- MemoryToCache  out  DATA_W  read data, registered.
- RespValid  out  1  one-cycle completion pulse, for both reads and writes.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, RespValid=0, MemoryToCache=0, latency counter=0.
  - All store words cleared to 0.
  - ReqReady=1 once reset deasserts.
- Handshake:
  - A request is accepted at a rising edge where ReqValid=1 and ReqReady=1.
  - On acceptance, address, data and RAMWE are latched into a request register. Inputs may change afterwards.
- ReqReady is combinational from state: 1 in IDLE and DONE, 0 in BUSY.
- FSM states are IDLE, BUSY and DONE.
- IDLE:
  - On accept: counter <= LATENCY-1, next state BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - Counter decrements each cycle.
  - ReqValid is ignored; the request is neither latched nor queued.
  - At the edge where counter==0, the access is performed:
    - write: store[addr] <= data;
    - read: MemoryToCache <= store[addr].
  - Next state DONE.
- DONE:
  - RespValid=1 for exactly this cycle.
  - If a new request is accepted at this edge, load the counter and go to BUSY. Otherwise go to IDLE.
- Latency:
  - Accept at edge E0 gives RespValid high during the cycle after edge E(LATENCY).
  - Back-to-back requests start one every LATENCY+1 cycles.
- MemoryToCache updates only on read completion. It holds its value through writes and idle periods.
- There is no response backpressure; RespValid is never stretched.
- Read-after-write to the same address, issued after the write's RespValid, returns the new data.
- Address wrap: none needed; every ADDR_W-bit value is a valid word.
- Reset mid-operation: the in-flight access is aborted.
  - A pending write does not update the store (the store is cleared anyway).
  - No RespValid is produced for the aborted request.
- ReqValid=1 while reset=0 is ignored.

Optional Feature:
- Macro: BACKING_MEMORY_STATS_EN.
- Defined: adds two outputs.
  - ReadCount out 8, saturating count of completed reads.
  - WriteCount out 8, saturating count of completed writes.
  - Each increments on the DONE cycle of the matching request type.
  - Each holds at 255 and clears on reset.
- Undefined: no such ports or counters exist; all other behaviour is identical.

Test Plan:
- Write then read: with LATENCY=3, after reset accept a write of 0x5A to address 0x2B at edge E0.
  - Required: RespValid high only after E3, ReqReady=0 during BUSY.
  - Then read 0x2B: MemoryToCache=0x5A while RespValid=1.
- Unwritten read: after reset, read 0x3F -> MemoryToCache=0x00 with RespValid pulse. MemoryToCache then holds 0x00 through a following write to 0x01 of 0xFF.
- Back-to-back: write 0x11 to 0x05, re-assert ReqValid during DONE with a read of 0x05.
  - Required: accepted in DONE; second RespValid exactly LATENCY+1 cycles after the first; data 0x11.
- Request during BUSY: hold ReqValid=1 with a write of 0x77 to 0x10 throughout a BUSY period of a read of 0x20.
  - Required: exactly one additional access is accepted, and only at DONE; store[0x10]=0x77 after its RespValid.
- Reset mid-write: drive reset=0 one cycle into BUSY of a write of 0xAA to 0x08.
  - Required: RespValid never pulses; after release, a read of 0x08 returns 0x00.
- With BACKING_MEMORY_STATS_EN defined: perform 3 reads and 2 writes -> ReadCount=3, WriteCount=2. After 300 reads, ReadCount=255. Reset -> both counts 0.
